// File: rtl/bali_pkg.sv
// Definitions shared by the fetch stage and control: fetch FSM states,
// opcode values and the instruction-length rule both sides must agree on.
package bali_pkg;

    typedef enum logic [2:0] {
        S_OP_REQ,
        S_OP_CAP,
        S_A1_REQ,
        S_A1_CAP,
        S_A2_REQ,
        S_A2_CAP,
        S_EXEC
    } fetch_state_t;

    localparam logic [7:0] NOP       = 8'h00;
    localparam logic [7:0] ICONST_M1 = 8'h02;
    localparam logic [7:0] ICONST_2  = 8'h05;
    localparam logic [7:0] BIPUSH    = 8'h10;
    localparam logic [7:0] SIPUSH    = 8'h11;
    localparam logic [7:0] ILOAD     = 8'h15;
    localparam logic [7:0] ISTORE    = 8'h36;
    localparam logic [7:0] IADD      = 8'h60;
    localparam logic [7:0] IINC      = 8'h84;
    localparam logic [7:0] IFEQ      = 8'h99;
    localparam logic [7:0] IF_ICMPLE = 8'hA4;
    localparam logic [7:0] GOTO      = 8'hA7;

    // Number of immediate bytes following an opcode; the whole
    // conditional-branch range through GOTO carries a 16-bit offset.
    function automatic logic [1:0] arg_len(input logic [7:0] opcode);
        logic [1:0] len;
        len = 2'd0;
        if (opcode == BIPUSH || opcode == ILOAD || opcode == ISTORE) begin
            len = 2'd1;
        end else if (opcode == SIPUSH || opcode == IINC ||
                     (opcode >= IFEQ && opcode <= GOTO)) begin
            len = 2'd2;
        end
        return len;
    endfunction

endpackage

// File: rtl/bytecode_fetch.sv
// Bytecode fetch stage: reads opcode and immediate bytes one per access,
// issues the assembled instruction to control and owns the program counter.
module bytecode_fetch
    import bali_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        op_code,
    output logic [7:0]        arg1,
    output logic [7:0]        arg2,
    output logic              instr_valid,
    input  logic              op_done,
    input  logic              jmp,
    input  logic [15:0]       jmpaddr,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        opc;
    logic [7:0]        a1;
    logic [1:0]        n_args;
    logic              rd_valid;
    logic              ld_opc;
    logic              ld_a1;
    logic              issue;
    logic              leave_exec;
    logic [7:0]        iss_op;
    logic [7:0]        iss_a1;
    logic [7:0]        iss_a2;
    logic              unused_jmp_hi;

    assign unused_jmp_hi = ^jmpaddr;

    // rd_valid is low in the first enabled cycle after a stall, meaning the
    // read issued before the stall is gone and a capture state must re-request.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = mem_addr;
        ld_opc     = 1'b0;
        ld_a1      = 1'b0;
        issue      = 1'b0;
        leave_exec = 1'b0;
        iss_op     = 8'h00;
        iss_a1     = 8'h00;
        iss_a2     = 8'h00;
        if (en) begin
            case (state)
                S_OP_REQ: begin
                    addr_next  = pc;
                    state_next = S_OP_CAP;
                end
                S_OP_CAP: begin
                    if (!rd_valid) begin
                        state_next = S_OP_REQ;
                    end else begin
                        ld_opc  = 1'b1;
                        pc_next = pc + ADDR_W'(1);
                        if (arg_len(mem_rdata) != 2'd0) begin
                            state_next = S_A1_REQ;
                        end else begin
                            state_next = S_EXEC;
                            issue      = 1'b1;
                            iss_op     = mem_rdata;
                        end
                    end
                end
                S_A1_REQ: begin
                    addr_next  = pc;
                    state_next = S_A1_CAP;
                end
                S_A1_CAP: begin
                    if (!rd_valid) begin
                        state_next = S_A1_REQ;
                    end else begin
                        ld_a1   = 1'b1;
                        pc_next = pc + ADDR_W'(1);
                        if (n_args == 2'd2) begin
                            state_next = S_A2_REQ;
                        end else begin
                            state_next = S_EXEC;
                            issue      = 1'b1;
                            iss_op     = opc;
                            iss_a1     = mem_rdata;
                        end
                    end
                end
                S_A2_REQ: begin
                    addr_next  = pc;
                    state_next = S_A2_CAP;
                end
                S_A2_CAP: begin
                    if (!rd_valid) begin
                        state_next = S_A2_REQ;
                    end else begin
                        pc_next    = pc + ADDR_W'(1);
                        state_next = S_EXEC;
                        issue      = 1'b1;
                        iss_op     = opc;
                        iss_a1     = a1;
                        iss_a2     = mem_rdata;
                    end
                end
                S_EXEC: begin
                    if (op_done) begin
                        leave_exec = 1'b1;
                        state_next = S_OP_REQ;
                        if (jmp) begin
                            pc_next = jmpaddr[ADDR_W-1:0];
                        end
                    end
                end
                default: begin
                    state_next = S_OP_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_OP_REQ;
            pc       <= '0;
            mem_addr <= '0;
            opc      <= 8'h00;
            a1       <= 8'h00;
            n_args   <= 2'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= en;
            state    <= state_next;
            pc       <= pc_next;
            mem_addr <= addr_next;
            if (ld_opc) begin
                opc    <= mem_rdata;
                n_args <= arg_len(mem_rdata);
            end
            if (ld_a1) begin
                a1 <= mem_rdata;
            end
        end
    end

    // Issued instruction is loaded once on entry to S_EXEC and cleared to nop
    // when control retires it, so control never sees stale argument bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_code     <= 8'h00;
            arg1        <= 8'h00;
            arg2        <= 8'h00;
            instr_valid <= 1'b0;
        end else if (issue) begin
            op_code     <= iss_op;
            arg1        <= iss_a1;
            arg2        <= iss_a2;
            instr_valid <= 1'b1;
        end else if (leave_exec) begin
            op_code     <= 8'h00;
            arg1        <= 8'h00;
            arg2        <= 8'h00;
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Self-checking bench for bytecode_fetch: directed scenarios plus a randomized
// program run against an instruction-level reference model.
module tb_bytecode_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        op_done;
    logic        jmp;
    logic [15:0] jmpaddr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  op_code;
    logic [7:0]  arg1;
    logic [7:0]  arg2;
    logic        instr_valid;
    logic [15:0] pc;

    logic        op_done4;
    logic        jmp4;
    logic [15:0] jmpaddr4;
    logic [3:0]  mem_addr4;
    logic [7:0]  mem_rdata4;
    logic [7:0]  op_code4;
    logic [7:0]  arg1_4;
    logic [7:0]  arg2_4;
    logic        instr_valid4;
    logic [3:0]  pc4;

    logic [7:0]  mem  [256];
    logic [7:0]  mem4 [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory's address register is the DUT's mem_addr, so data follows it by one cycle.
    assign mem_rdata  = mem[mem_addr[7:0]];
    assign mem_rdata4 = mem4[mem_addr4];

    bytecode_fetch #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .op_code(op_code), .arg1(arg1), .arg2(arg2), .instr_valid(instr_valid),
        .op_done(op_done), .jmp(jmp), .jmpaddr(jmpaddr), .pc(pc)
    );

    bytecode_fetch #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
        .op_code(op_code4), .arg1(arg1_4), .arg2(arg2_4), .instr_valid(instr_valid4),
        .op_done(op_done4), .jmp(jmp4), .jmpaddr(jmpaddr4), .pc(pc4)
    );

    function automatic int exp_len(input logic [7:0] op);
        if (op == 8'h10 || op == 8'h15 || op == 8'h36) return 1;
        if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA7)) return 2;
        return 0;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; op_done = 1'b0; jmp = 1'b0; jmpaddr = 16'h0;
        op_done4 = 1'b0; jmp4 = 1'b0; jmpaddr4 = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Counts rising edges until an instruction is issued; bounded.
    task automatic wait_issue(input int start, output int cycles, output bit timed_out);
        cycles = start;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (instr_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic retire(input bit j, input logic [15:0] addr);
        op_done = 1'b1; jmp = j; jmpaddr = addr;
        @(posedge clk); #1;
        op_done = 1'b0; jmp = 1'b0;
    endtask

    task automatic test_reset();
        int cyc; bit to;
        rst = 1'b1; en = 1'b1; op_done = 1'b0; jmp = 1'b0; jmpaddr = 16'h0;
        op_done4 = 1'b0; jmp4 = 1'b0; jmpaddr4 = 16'h0;
        #1;
        n_cmp++;
        if (pc !== 16'h0 || mem_addr !== 16'h0 || op_code !== 8'h00 || instr_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_state: pc=%h mem_addr=%h op=%h valid=%b, want 0/0/00/0",
                     pc, mem_addr, op_code, instr_valid);
        end
        clear_mem();
        mem[4] = 8'h10; mem[5] = 8'h33;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_issue(0, cyc, to);
            retire(1'b0, 16'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (pc !== 16'd5) begin
            n_err++;
            $display("[TB] FAIL reset_pre_pc: pc=%h want 0005", pc);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 16'h0 || op_code !== 8'h00 || instr_valid !== 1'b0 || mem_addr !== 16'h0) begin
            n_err++;
            $display("[TB] FAIL reset_async: pc=%h op=%h valid=%b mem_addr=%h, want 0/00/0/0",
                     pc, op_code, instr_valid, mem_addr);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_addr !== 16'h0) begin
            n_err++;
            $display("[TB] FAIL reset_first_addr: mem_addr=%h want 0000", mem_addr);
        end
        wait_issue(1, cyc, to);
        n_cmp++;
        if (to || cyc != 2 || op_code !== 8'h00 || pc !== 16'd1) begin
            n_err++;
            $display("[TB] FAIL reset_first_issue: to=%0d cyc=%0d op=%h pc=%h, want 0/2/00/0001",
                     to, cyc, op_code, pc);
        end
    endtask

    task automatic test_no_args();
        int cyc; bit to;
        logic [7:0] prog [4];
        prog[0] = 8'h02; prog[1] = 8'h05; prog[2] = 8'h05; prog[3] = 8'h60;
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_issue(0, cyc, to);
            n_cmp++;
            if (to || cyc != 2 || op_code !== prog[k] || arg1 !== 8'h00 || arg2 !== 8'h00 ||
                pc !== 16'(k + 1)) begin
                n_err++;
                $display("[TB] FAIL no_args[%0d]: to=%0d cyc=%0d op=%h a1=%h a2=%h pc=%h, want 0/2/%h/00/00/%h",
                         k, to, cyc, op_code, arg1, arg2, pc, prog[k], 16'(k + 1));
            end
            repeat (2) @(posedge clk);
            #1;
            retire(1'b0, 16'h0);
            n_cmp++;
            if (instr_valid !== 1'b0 || op_code !== 8'h00) begin
                n_err++;
                $display("[TB] FAIL no_args_nop[%0d]: valid=%b op=%h, want 0/00", k, instr_valid, op_code);
            end
        end
    endtask

    task automatic test_args();
        int cyc; bit to;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h7F; mem[2] = 8'h11; mem[3] = 8'h12; mem[4] = 8'h34;
        do_reset();
        wait_issue(0, cyc, to);
        n_cmp++;
        if (to || cyc != 4 || op_code !== 8'h10 || arg1 !== 8'h7F || arg2 !== 8'h00 || pc !== 16'd2) begin
            n_err++;
            $display("[TB] FAIL one_arg: to=%0d cyc=%0d op=%h a1=%h a2=%h pc=%h, want 0/4/10/7f/00/0002",
                     to, cyc, op_code, arg1, arg2, pc);
        end
        retire(1'b0, 16'h0);
        wait_issue(0, cyc, to);
        n_cmp++;
        if (to || cyc != 6 || op_code !== 8'h11 || arg1 !== 8'h12 || arg2 !== 8'h34 || pc !== 16'd5) begin
            n_err++;
            $display("[TB] FAIL two_args: to=%0d cyc=%0d op=%h a1=%h a2=%h pc=%h, want 0/6/11/12/34/0005",
                     to, cyc, op_code, arg1, arg2, pc);
        end
    endtask

    task automatic test_jump();
        int cyc; bit to;
        logic [15:0] tgt;
        for (int jj = 0; jj < 2; jj++) begin
            clear_mem();
            mem[8] = 8'hA7; mem[9] = 8'h00; mem[10] = 8'h04;
            mem[11] = 8'h60; mem[12] = 8'h02;
            do_reset();
            for (int k = 0; k < 8; k++) begin
                wait_issue(0, cyc, to);
                retire(1'b0, 16'h0);
            end
            wait_issue(0, cyc, to);
            n_cmp++;
            if (to || op_code !== 8'hA7 || arg1 !== 8'h00 || arg2 !== 8'h04 || pc !== 16'h000B) begin
                n_err++;
                $display("[TB] FAIL goto_issue[%0d]: to=%0d op=%h a1=%h a2=%h pc=%h, want 0/a7/00/04/000b",
                         jj, to, op_code, arg1, arg2, pc);
            end
            tgt = (jj == 0) ? 16'h000C : 16'h000B;
            retire(jj == 0, 16'h000C);
            n_cmp++;
            if (pc !== tgt) begin
                n_err++;
                $display("[TB] FAIL goto_pc[%0d]: pc=%h want %h", jj, pc, tgt);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (mem_addr !== tgt) begin
                n_err++;
                $display("[TB] FAIL goto_addr[%0d]: mem_addr=%h want %h", jj, mem_addr, tgt);
            end
            wait_issue(1, cyc, to);
            n_cmp++;
            if (to || cyc != 2 || op_code !== mem[tgt[7:0]]) begin
                n_err++;
                $display("[TB] FAIL goto_target[%0d]: to=%0d cyc=%0d op=%h, want 0/2/%h",
                         jj, to, cyc, op_code, mem[tgt[7:0]]);
            end
        end
    endtask

    task automatic test_stall();
        int cyc; bit to;
        clear_mem();
        mem[1] = 8'h10; mem[2] = 8'h55; mem[3] = 8'h60;
        do_reset();
        wait_issue(0, cyc, to);
        retire(1'b0, 16'h0);
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (pc !== 16'd2 || mem_addr !== 16'd2 || instr_valid !== 1'b0 || op_code !== 8'h00) begin
                n_err++;
                $display("[TB] FAIL stall_cap[%0d]: pc=%h mem_addr=%h valid=%b op=%h, want 0002/0002/0/00",
                         k, pc, mem_addr, instr_valid, op_code);
            end
        end
        en = 1'b1;
        wait_issue(0, cyc, to);
        n_cmp++;
        if (to || op_code !== 8'h10 || arg1 !== 8'h55 || arg2 !== 8'h00 || pc !== 16'd3) begin
            n_err++;
            $display("[TB] FAIL stall_cap_issue: to=%0d op=%h a1=%h a2=%h pc=%h, want 0/10/55/00/0003",
                     to, op_code, arg1, arg2, pc);
        end
        en = 1'b0;
        op_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (instr_valid !== 1'b1 || op_code !== 8'h10 || arg1 !== 8'h55 || pc !== 16'd3) begin
                n_err++;
                $display("[TB] FAIL stall_exec[%0d]: valid=%b op=%h a1=%h pc=%h, want 1/10/55/0003",
                         k, instr_valid, op_code, arg1, pc);
            end
        end
        op_done = 1'b0;
        en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (instr_valid !== 1'b1 || op_code !== 8'h10) begin
            n_err++;
            $display("[TB] FAIL stall_exec_hold: valid=%b op=%h, want 1/10", instr_valid, op_code);
        end
        retire(1'b0, 16'h0);
        wait_issue(0, cyc, to);
        n_cmp++;
        if (to || cyc != 2 || op_code !== 8'h60 || pc !== 16'd4) begin
            n_err++;
            $display("[TB] FAIL stall_next: to=%0d cyc=%0d op=%h pc=%h, want 0/2/60/0004",
                     to, cyc, op_code, pc);
        end
    endtask

    task automatic test_wrap4();
        int cyc; bit to;
        for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
        mem4[0] = 8'h05; mem4[15] = 8'h10;
        do_reset();
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (instr_valid4) begin to = 1'b0; break; end
        end
        n_cmp++;
        if (to || op_code4 !== 8'h05 || pc4 !== 4'd1) begin
            n_err++;
            $display("[TB] FAIL wrap_first: to=%0d op=%h pc=%h, want 0/05/1", to, op_code4, pc4);
        end
        op_done4 = 1'b1; jmp4 = 1'b1; jmpaddr4 = 16'hFFFF;
        @(posedge clk); #1;
        op_done4 = 1'b0; jmp4 = 1'b0;
        n_cmp++;
        if (pc4 !== 4'hF) begin
            n_err++;
            $display("[TB] FAIL wrap_jmp_pc: pc=%h want f", pc4);
        end
        to = 1'b1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (instr_valid4) begin to = 1'b0; break; end
        end
        n_cmp++;
        if (to || cyc != 4 || op_code4 !== 8'h10 || arg1_4 !== 8'h05 || arg2_4 !== 8'h00 || pc4 !== 4'd1) begin
            n_err++;
            $display("[TB] FAIL wrap_arg: to=%0d cyc=%0d op=%h a1=%h a2=%h pc=%h, want 0/4/10/05/00/1",
                     to, cyc, op_code4, arg1_4, arg2_4, pc4);
        end
    endtask

    task automatic test_random();
        int cyc; bit to; int n; int hold; bit j;
        logic [15:0] exp_pc, p1, p2, after, tgt;
        logic [7:0] e_op, e_a1, e_a2;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        exp_pc = 16'h0;
        for (int k = 0; k < 40; k++) begin
            e_op  = mem[exp_pc[7:0]];
            n     = exp_len(e_op);
            p1    = exp_pc + 16'd1;
            p2    = exp_pc + 16'd2;
            e_a1  = (n >= 1) ? mem[p1[7:0]] : 8'h00;
            e_a2  = (n == 2) ? mem[p2[7:0]] : 8'h00;
            after = exp_pc + 16'(1 + n);
            wait_issue(0, cyc, to);
            n_cmp++;
            if (to || cyc != 2 + 2 * n || op_code !== e_op || arg1 !== e_a1 || arg2 !== e_a2 ||
                pc !== after) begin
                n_err++;
                $display("[TB] FAIL random[%0d]: to=%0d cyc=%0d op=%h a1=%h a2=%h pc=%h, want 0/%0d/%h/%h/%h/%h",
                         k, to, cyc, op_code, arg1, arg2, pc, 2 + 2 * n, e_op, e_a1, e_a2, after);
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                n_cmp++;
                if (instr_valid !== 1'b1 || op_code !== e_op || arg1 !== e_a1 || arg2 !== e_a2) begin
                    n_err++;
                    $display("[TB] FAIL random_hold[%0d]: valid=%b op=%h a1=%h a2=%h, want 1/%h/%h/%h",
                             k, instr_valid, op_code, arg1, arg2, e_op, e_a1, e_a2);
                end
            end
            j   = ($urandom_range(0, 3) == 0);
            tgt = 16'($urandom);
            retire(j, tgt);
            exp_pc = j ? tgt : after;
            n_cmp++;
            if (instr_valid !== 1'b0 || op_code !== 8'h00 || pc !== exp_pc) begin
                n_err++;
                $display("[TB] FAIL random_retire[%0d]: valid=%b op=%h pc=%h, want 0/00/%h",
                         k, instr_valid, op_code, pc, exp_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_args();
        test_args();
        test_jump();
        test_stall();
        test_wrap4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bytecode_fetch.md
Name: bytecode_fetch

Overview:
- Instruction fetch stage directly upstream of control.
- Reads the bytecode stream one byte per access from synchronous program memory.
- Assembles each opcode with its 0-2 immediate argument bytes, presents op_code/arg1/arg2 to control, and holds them until control reports op_done.
- Owns the program counter; redirects it when control signals jmp.

Parameters:
- ADDR_W, 16, program memory address / pc width in bits; 1..16.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  fetch enable; 0 freezes the state machine, registers hold
- mem_addr  out  ADDR_W  program memory byte address (registered)
- mem_rdata  in  8  program memory data; valid exactly 1 cycle after mem_addr is driven
- op_code  out  8  opcode to control; 8'h00 (nop) when no instruction is issued
- arg1  out  8  first immediate byte; 8'h00 if unused
- arg2  out  8  second immediate byte; 8'h00 if unused
- instr_valid  out  1  high while op_code/arg1/arg2 carry an issued instruction
- op_done  in  1  control finished the current instruction; sampled only in S_EXEC
- jmp  in  1  control requests redirect; sampled only with op_done in S_EXEC
- jmpaddr  in  16  absolute jump target; low ADDR_W bits used
- pc  out  ADDR_W  current program counter

Behaviour:
- Reset (async, any state): state=S_OP_REQ, pc=0, mem_addr=0, op_code=arg1=arg2=8'h00, instr_valid=0.
- State S_OP_REQ: mem_addr<=pc; go to S_OP_CAP.
- State S_OP_CAP: opc<=mem_rdata; n<=arg_len(mem_rdata); pc<=pc+1; go to S_A1_REQ if n>0, else to S_EXEC.
- State S_A1_REQ: mem_addr<=pc; go to S_A1_CAP.
- State S_A1_CAP: a1<=mem_rdata; pc<=pc+1; go to S_A2_REQ if n==2, else to S_EXEC.
- State S_A2_REQ / S_A2_CAP: same pattern; a2<=mem_rdata; pc<=pc+1; go to S_EXEC.
- Issue: on entry to S_EXEC, op_code/arg1/arg2 are registered from opc/a1/a2 and instr_valid<=1. They are held stable for the whole of S_EXEC.
- Outside S_EXEC: op_code/arg1/arg2=8'h00 and instr_valid=0. Control sees nop.
- S_EXEC, op_done=0: stay.
- S_EXEC, op_done=1, jmp=0: pc unchanged (already points past the args); go to S_OP_REQ; outputs return to nop next cycle.
- S_EXEC, op_done=1, jmp=1: pc<=jmpaddr[ADDR_W-1:0]; go to S_OP_REQ.
- op_done or jmp outside S_EXEC: ignored.
- Latency from entering S_OP_REQ to instr_valid=1: 2 cycles for 0 args, 4 for 1 arg, 6 for 2 args.
- pc wraps modulo 2^ADDR_W with no flag. Arguments that straddle the wrap are fetched from address 0 onward.
- en=0: no state, pc, mem_addr or output change. A memory read already in flight is lost, so a S_*_CAP state re-issues its read: on en rising, resume at the matching S_*_REQ.
- Unused arguments (n<2) are driven as 8'h00, never stale values.

Decomposition:
- Shared package bali_pkg:
  - fetch_state_t enum: S_OP_REQ, S_OP_CAP, S_A1_REQ, S_A1_CAP, S_A2_REQ, S_A2_CAP, S_EXEC.
  - Opcode localparams: NOP=8'h00, ICONST_M1=8'h02, ICONST_2=8'h05, BIPUSH=8'h10, SIPUSH=8'h11, ILOAD=8'h15, ISTORE=8'h36, IADD=8'h60, IINC=8'h84, IFEQ..IF_ICMPLE=8'h99..8'hA4, GOTO=8'hA7.
  - Function arg_len(opcode) -> 2 bits:
    - BIPUSH/ILOAD/ISTORE=1
    - SIPUSH/IINC/8'h99..8'hA7=2
    - else 0
- The package is shared with control so both agree on instruction length.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Reset: assert rst mid-S_A1_CAP with pc=5 -> same cycle pc=0, op_code=00, instr_valid=0; after release, first mem_addr=0.
- Memory 02 05 05 60, op_done pulsed 3 cycles after each issue -> issued op_codes 02,05,05,60 in order, each 2 cycles after the previous S_OP_REQ; arg1=arg2=00; pc=1,2,3,4.
- Memory 10 7F 11 12 34 -> issue op 10/arg1 7F/arg2 00, then op 11/arg1 12/arg2 34; pc=2 then 5; 4- and 6-cycle fetch latency.
- GOTO at addr 8 (A7 00 04), control returns jmp=1, jmpaddr=16'h000C with op_done -> next mem_addr=0x0C, pc=0x0C. Same case with jmp=0 -> next mem_addr=0x0B.
- en=0 for 5 cycles during S_A1_CAP and during S_EXEC -> outputs and pc frozen; after en=1 the correct arg byte is re-read and issued, with no duplicate or skipped instruction.
- ADDR_W=4, BIPUSH at addr 15 with arg at addr 0 -> arg1=mem[0], pc=1 after capture.
